// File: rtl/nxn_switch_allocator_if.sv
// Router crossbar allocation bundle: input-side requests, output-side readiness,
// and the crossbar select / valid / grant results.
interface nxn_switch_allocator_if #(
   parameter int IN_N  = 5,
   parameter int OUT_M = 5
);
   localparam int SEL_W = $clog2(IN_N);
   localparam int DST_W = $clog2(OUT_M);

   logic [IN_N-1:0]        valid_i;
   logic [IN_N-1:0]        tail_i;
   logic [IN_N*DST_W-1:0]  dst_i;
   logic [OUT_M-1:0]       out_ready_i;
   logic [OUT_M*SEL_W-1:0] sel_o;
   logic [OUT_M-1:0]       out_valid_o;
   logic [IN_N-1:0]        grant_o;

   // Upstream/downstream side that presents flits and consumes results.
   modport master (
      output valid_i, tail_i, dst_i, out_ready_i,
      input  sel_o, out_valid_o, grant_o
   );

   // Allocator side.
   modport slave (
      input  valid_i, tail_i, dst_i, out_ready_i,
      output sel_o, out_valid_o, grant_o
   );
endinterface

// File: rtl/nxn_switch_allocator.sv
// Wormhole switch allocator: one round-robin arbiter per output, each output
// locked to its winning input until that packet's tail flit transfers.
//
// state     | meaning
// ST_IDLE   | output free; arbitrates among eligible inputs this cycle
// ST_LOCKED | output owned by owner_q; flits flow when valid and ready
module nxn_switch_allocator #(
   parameter int IN_N  = 5,
   parameter int OUT_M = 5
) (
   input logic                  clk_i,
   input logic                  rst_i,
   nxn_switch_allocator_if.slave bus
);
   localparam int SEL_W = $clog2(IN_N);
   localparam int DST_W = $clog2(OUT_M);

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t           state_q  [OUT_M];
   state_t           state_d  [OUT_M];
   logic [SEL_W-1:0] owner_q  [OUT_M];
   logic [SEL_W-1:0] owner_d  [OUT_M];
   logic [SEL_W-1:0] rr_ptr_q [OUT_M];
   logic [SEL_W-1:0] rr_ptr_d [OUT_M];
   logic [IN_N-1:0]  busy_q;
   logic [IN_N-1:0]  busy_d;

   logic [IN_N-1:0]        grant;
   logic [OUT_M-1:0]       out_valid;
   logic [OUT_M-1:0]       xfer_tail;
   logic [OUT_M*SEL_W-1:0] sel;

   // Crossbar controls: select comes only from owner registers, valid/grant
   // are combinational from the owning input's valid and the output's ready.
   always_comb begin
      grant     = '0;
      out_valid = '0;
      xfer_tail = '0;
      sel       = '0;
      for (int o = 0; o < OUT_M; o++) begin
         sel[o*SEL_W +: SEL_W] = owner_q[o];
         if (state_q[o] == ST_LOCKED) begin
            out_valid[o] = bus.valid_i[owner_q[o]];
            if (bus.valid_i[owner_q[o]] && bus.out_ready_i[o]) begin
               grant[owner_q[o]] = 1'b1;
               xfer_tail[o]      = bus.tail_i[owner_q[o]];
            end
         end
      end
   end

   assign bus.sel_o       = sel;
   assign bus.out_valid_o = out_valid;
   assign bus.grant_o     = grant;

   // Per-output arbitration and lock release; busy keeps a locked input out
   // of every other output's arbitration even if its dst changes.
   always_comb begin
      logic found;
      int   idx;
      busy_d = busy_q;
      found  = 1'b0;
      idx    = 0;
      for (int o = 0; o < OUT_M; o++) begin
         state_d[o]  = state_q[o];
         owner_d[o]  = owner_q[o];
         rr_ptr_d[o] = rr_ptr_q[o];
         if (state_q[o] == ST_IDLE) begin
            found = 1'b0;
            for (int k = 0; k < IN_N; k++) begin
               idx = int'(rr_ptr_q[o]) + k;
               if (idx >= IN_N) idx = idx - IN_N;
               if (!found && bus.valid_i[idx] && !busy_q[idx] &&
                   bus.dst_i[idx*DST_W +: DST_W] == DST_W'(o)) begin
                  found       = 1'b1;
                  owner_d[o]  = SEL_W'(idx);
                  state_d[o]  = ST_LOCKED;
                  busy_d[idx] = 1'b1;
               end
            end
         end else if (xfer_tail[o]) begin
            state_d[o]          = ST_IDLE;
            busy_d[owner_q[o]]  = 1'b0;
            rr_ptr_d[o]         = (owner_q[o] == SEL_W'(IN_N-1)) ? '0 : owner_q[o] + SEL_W'(1);
         end
      end
   end

   // State registers with synchronous reset; reset abandons any partial packet.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= '0;
         for (int o = 0; o < OUT_M; o++) begin
            state_q[o]  <= ST_IDLE;
            owner_q[o]  <= '0;
            rr_ptr_q[o] <= '0;
         end
      end else begin
         busy_q <= busy_d;
         for (int o = 0; o < OUT_M; o++) begin
            state_q[o]  <= state_d[o];
            owner_q[o]  <= owner_d[o];
            rr_ptr_q[o] <= rr_ptr_d[o];
         end
      end
   end
endmodule
